output_ram_ctrl: RTL and testbench

// - Sequences the accelerator's output RAM: FILL captures a frame of result words from the compute core, DRAIN streams them out to the host/DMA.
// - Drives the RAM's write and read ports directly; sits between the core result stream and the output DMA.
// - Hides the RAM's 1-cycle registered read latency behind a 2-entry output buffer, so out_* is a clean valid/ready stream.

---
 rtl/output_ram_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_output_ram_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_ram_ctrl.sv
// Output RAM sequencer: FILL writes a frame of core results into the RAM, DRAIN streams it back out
// through a 2-entry buffer that hides the 1-cycle RAM read latency. Optional abort port: OUT_RAM_CTRL_ABORT_EN.
module output_ram_ctrl #(
    parameter int ADD_SIZE    = 11,
    parameter int DATA_SIZE   = 32,
    parameter int FRAME_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef OUT_RAM_CTRL_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_last,
    output logic                 ram_write_en,
    output logic [ADD_SIZE-1:0]  ram_write_address,
    output logic [DATA_SIZE-1:0] ram_write_data,
    output logic                 ram_read_en,
    output logic [ADD_SIZE-1:0]  ram_read_address,
    input  logic [DATA_SIZE-1:0] ram_read_data
);

    localparam int CW = ADD_SIZE + 1;
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_WORDS);
    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_WORDS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    generate
        if (FRAME_WORDS < 1 || FRAME_WORDS > (1 << ADD_SIZE)) begin : g_bad_frame
            $error("output_ram_ctrl: FRAME_WORDS must be in 1..2**ADD_SIZE");
        end
    endgenerate

    logic [1:0]           state_r;
    logic [CW-1:0]        wcnt_r;
    logic [CW-1:0]        rcnt_r;
    logic [CW-1:0]        ocnt_r;
    logic [DATA_SIZE-1:0] buf0_r;
    logic [DATA_SIZE-1:0] buf1_r;
    logic [1:0]           bcnt_r;
    logic                 flight_r;
    logic                 done_r;

    logic                 abort_s;
    logic                 wr_s;
    logic                 rd_s;
    logic                 pop_s;
    logic [2:0]           occ_s;

`ifdef OUT_RAM_CTRL_ABORT_EN
    assign abort_s = abort && (state_r != ST_IDLE);
`else
    assign abort_s = 1'b0;
`endif

    // Occupancy after this cycle's pop; counting the pop lets a refill issue the same cycle for full rate.
    assign occ_s = {1'b0, bcnt_r} + {2'b00, flight_r} - {2'b00, pop_s};
    assign pop_s = (bcnt_r != 2'd0) && out_ready;
    assign wr_s  = (state_r == ST_FILL) && in_valid;
    assign rd_s  = (state_r == ST_DRAIN) && !done_r && !abort_s
                   && (rcnt_r != FRAME_CNT) && (occ_s < 3'd2);

    assign busy              = (state_r != ST_IDLE);
    assign done              = done_r;
    assign in_ready          = (state_r == ST_FILL);
    assign ram_write_en      = wr_s;
    assign ram_write_address = wr_s ? wcnt_r[ADD_SIZE-1:0] : {ADD_SIZE{1'b0}};
    assign ram_write_data    = wr_s ? in_data : {DATA_SIZE{1'b0}};
    assign ram_read_en       = rd_s;
    assign ram_read_address  = rd_s ? rcnt_r[ADD_SIZE-1:0] : {ADD_SIZE{1'b0}};
    assign out_valid         = (bcnt_r != 2'd0);
    assign out_data          = buf0_r;
    assign out_last          = out_valid && (ocnt_r == LAST_IDX);

    // Frame sequencing and the write/read/output counters; DRAIN lingers one cycle for the done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            wcnt_r  <= {CW{1'b0}};
            rcnt_r  <= {CW{1'b0}};
            ocnt_r  <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_FILL;
                        wcnt_r  <= {CW{1'b0}};
                        rcnt_r  <= {CW{1'b0}};
                        ocnt_r  <= {CW{1'b0}};
                    end
                end
                ST_FILL: begin
                    if (abort_s) begin
                        state_r <= ST_IDLE;
                    end else if (wr_s) begin
                        wcnt_r <= wcnt_r + {{(CW-1){1'b0}}, 1'b1};
                        if (wcnt_r == LAST_IDX) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort_s || done_r) begin
                        state_r <= ST_IDLE;
                    end else begin
                        if (rd_s) begin
                            rcnt_r <= rcnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                        if (pop_s) begin
                            ocnt_r <= ocnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Done pulses the cycle after the final word is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == ST_DRAIN) && !done_r && !abort_s && pop_s && (ocnt_r == LAST_IDX);
        end
    end

    // Two-entry output buffer fed by the registered RAM read; flushed outside DRAIN or on abort.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf0_r   <= {DATA_SIZE{1'b0}};
            buf1_r   <= {DATA_SIZE{1'b0}};
            bcnt_r   <= 2'd0;
            flight_r <= 1'b0;
        end else if (abort_s || (state_r != ST_DRAIN)) begin
            bcnt_r   <= 2'd0;
            flight_r <= 1'b0;
        end else begin
            flight_r <= rd_s;
            case ({flight_r, pop_s})
                2'b10: begin
                    if (bcnt_r == 2'd0) begin
                        buf0_r <= ram_read_data;
                    end else begin
                        buf1_r <= ram_read_data;
                    end
                    bcnt_r <= bcnt_r + 2'd1;
                end
                2'b01: begin
                    buf0_r <= buf1_r;
                    bcnt_r <= bcnt_r - 2'd1;
                end
                2'b11: begin
                    if (bcnt_r == 2'd1) begin
                        buf0_r <= ram_read_data;
                    end else begin
                        buf0_r <= buf1_r;
                        buf1_r <= ram_read_data;
                    end
                end
                default: begin
                    bcnt_r <= bcnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_ram_ctrl.sv
// Bench for output_ram_ctrl (FRAME_WORDS=8): frame-level model of fill/drain checked every cycle.
module tb_output_ram_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, in_ready, out_valid, out_last;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          ram_write_en, ram_read_en;
    logic [AW-1:0] ram_write_address, ram_read_address;
    logic [DW-1:0] ram_write_data;
    logic [DW-1:0] ram_read_data = '0;
    logic [DW-1:0] mem [1 << AW];

    int total = 0;
    int bad = 0;
    int phase = 0;
    int wr_n = 0;
    int rd_n = 0;
    int pop_n = 0;
    int cyc = 0;
    int drain_cyc = 0;
    int last_pop_cyc = 0;
    bit pend_done = 1'b0;
    bit prev_stall = 1'b0;
    bit tput = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW-1:0] frame [FW];

    output_ram_ctrl #(.ADD_SIZE(AW), .DATA_SIZE(DW), .FRAME_WORDS(FW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef OUT_RAM_CTRL_ABORT_EN
        .abort(abort),
`endif
        .busy(busy),
        .done(done),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .ram_write_en(ram_write_en),
        .ram_write_address(ram_write_address),
        .ram_write_data(ram_write_data),
        .ram_read_en(ram_read_en),
        .ram_read_address(ram_read_address),
        .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle registered read
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_address] <= ram_write_data;
        if (ram_read_en) ram_read_data <= mem[ram_read_address];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, check against the frame model, advance the model.
    task automatic step();
        bit pop;
        bit wr_exp;
        bit nxt_done;
        @(negedge clk);
        chk("busy", 64'(busy), 64'(phase != 0));
        chk("in_ready", 64'(in_ready), 64'(phase == 1));
        chk("done", 64'(done), 64'(pend_done));
        wr_exp = (phase == 1) && in_valid;
        chk("wr_en", 64'(ram_write_en), 64'(wr_exp));
        if (wr_exp) begin
            chk("wr_addr", 64'(ram_write_address), 64'(wr_n));
            chk("wr_data", 64'(ram_write_data), 64'(in_data));
            frame[wr_n] = in_data;
            wr_n++;
        end
        if (phase != 2) begin
            chk("rd_idle", 64'(ram_read_en), 64'd0);
            chk("ovalid_idle", 64'(out_valid), 64'd0);
        end else if (ram_read_en) begin
            chk("rd_addr", 64'(ram_read_address), 64'(rd_n));
            rd_n++;
        end
        if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(prev_data));
            chk("hold_last", 64'(out_last), 64'(prev_last));
        end
        pop = out_valid && out_ready;
        if (out_valid) begin
            if (pop_n >= FW) begin
                chk("extra_word", 64'(out_valid), 64'd0);
            end else begin
                chk("out_data", 64'(out_data), 64'(frame[pop_n]));
                chk("out_last", 64'(out_last), 64'(pop_n == FW - 1));
            end
        end
        if (pop) begin
            if (tput) begin
                if (pop_n == 0) chk("latency", 64'(cyc - drain_cyc), 64'd2);
                else chk("tput", 64'(cyc - last_pop_cyc), 64'd1);
            end
            last_pop_cyc = cyc;
            pop_n++;
        end
        chk("occupancy", 64'((rd_n - pop_n) <= 2), 64'd1);
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
        nxt_done = 1'b0;
        if (abort && phase != 0) begin
            phase = 0;
            prev_stall = 1'b0;
        end else begin
            case (phase)
                0: if (start) begin phase = 1; wr_n = 0; rd_n = 0; pop_n = 0; end
                1: if (wr_n == FW) begin phase = 2; drain_cyc = cyc + 1; end
                2: if (pend_done) phase = 0;
                   else if (pop && pop_n == FW) nxt_done = 1'b1;
                default: phase = 0;
            endcase
        end
        pend_done = nxt_done;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fill(input int gap, input bit rnd, input bit noise);
        start = 1'b1;
        step();
        for (int i = 0; i < FW; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data = $urandom;
                start = noise;
                step();
            end
            in_valid = 1'b1;
            in_data = rnd ? DW'($urandom) : DW'(32'hA0 + i);
            start = noise;
            step();
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic drain(input bit rnd, input bit noise);
        int c = 0;
        while (phase != 0 && c < 400) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = noise ? 1'($urandom_range(0, 1)) : pend_done;
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data = $urandom;
            step();
            c++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk("drain_timeout", 64'(phase == 0), 64'd1);
        chk("words_out", 64'(pop_n), 64'(FW));
    endtask

    initial begin
        // Reset held 3 cycles with start/in_valid asserted
        rst = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_wr_en", 64'(ram_write_en), 64'd0);
        chk("rst_wr_addr", 64'(ram_write_address), 64'd0);
        chk("rst_wr_data", 64'(ram_write_data), 64'd0);
        chk("rst_rd_en", 64'(ram_read_en), 64'd0);
        chk("rst_rd_addr", 64'(ram_read_address), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        step();

        // Back-to-back fill of 0xA0..0xA7, full-rate drain, start coincident with done
        tput = 1'b1;
        fill(0, 1'b0, 1'b0);
        drain(1'b0, 1'b0);
        tput = 1'b0;
        repeat (2) step();

        // Random data with random backpressure
        fill(0, 1'b1, 1'b0);
        drain(1'b1, 1'b0);

        // Input gaps, stray start pulses and in_valid during DRAIN
        fill(3, 1'b0, 1'b1);
        drain(1'b0, 1'b1);
        fill(1, 1'b1, 1'b1);
        drain(1'b1, 1'b1);
        repeat (3) step();

`ifdef OUT_RAM_CTRL_ABORT_EN
        // Abort after three drained words, then a fresh frame from address 0
        fill(0, 1'b0, 1'b0);
        for (int c = 0; c < 50 && pop_n < 3; c++) begin
            out_ready = 1'b1;
            step();
        end
        chk("pre_abort_words", 64'(pop_n), 64'd3);
        out_ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        fill(0, 1'b1, 1'b0);
        drain(1'b1, 1'b0);
        repeat (2) step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
